// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: trigger, change-driven sampling, sample FIFO.
// Define LA_INPUT_SYNC_EN to add a two-flop synchronizer ahead of the input register.
module la_capture_core #(
   parameter int CH_W  = 8,
   parameter int TS_W  = 24,
   parameter int DEPTH = 256
) (
   input  logic                 i_clk,
   input  logic                 _mrst,
   input  logic [CH_W-1:0]      i_data,
   input  logic                 i_arm,
   input  logic                 i_stop,
   input  logic                 i_man_trig,
   input  logic                 i_clr,
   input  logic [CH_W-1:0]      i_trig_mask,
   input  logic [CH_W-1:0]      i_trig_value,
   input  logic [CH_W-1:0]      i_trig_edge,
   input  logic [31:0]          i_prescaler,
   input  logic                 i_do_limit,
   input  logic [31:0]          i_step_limit,
   input  logic                 i_read,
   output logic [TS_W+CH_W-1:0] o_data,
   output logic                 o_available,
   output logic                 o_full,
   output logic                 o_run,
   output logic                 o_trig,
   output logic                 o_done,
   output logic                 o_overflow,
   output logic [31:0]          o_count
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int REC_W  = TS_W + CH_W;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

   state_t            state_q;
   logic [CH_W-1:0]   pin_s;
   logic [CH_W-1:0]   d_q, prev_q;
   logic [31:0]       count_q, psc_q;
   logic [TS_W-1:0]   ts_q;
   logic              ovf_q;
   logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q;
   logic [REC_W-1:0]  mem_q [DEPTH];

`ifdef LA_INPUT_SYNC_EN
   logic [CH_W-1:0]   sync0_q, sync1_q;

   // Two-flop synchronizer for pins from another clock domain
   always_ff @(posedge i_clk) begin
      if (!_mrst) begin
         sync0_q <= '0;
         sync1_q <= '0;
      end else begin
         sync0_q <= i_data;
         sync1_q <= sync0_q;
      end
   end

   assign pin_s = sync1_q;
`else
   assign pin_s = i_data;
`endif

   // Current and previous sample; all matching compares these two
   always_ff @(posedge i_clk) begin
      if (!_mrst) begin
         d_q    <= '0;
         prev_q <= '0;
      end else begin
         d_q    <= pin_s;
         prev_q <= d_q;
      end
   end

   logic [CH_W-1:0]  lvl_ok, edge_ok, bit_ok;
   logic             trig_hit, tick, wrap, change, lim_hit;
   logic             empty, full, rd_ok, wr_req, wr_ok, wr_drop;
   logic [31:0]      psc_lim, lim, count_d;
   logic [TS_W-1:0]  ts_d, rec_ts;
   logic [REC_W-1:0] rec;

   assign lvl_ok  = ~(d_q ^ i_trig_value);
   assign edge_ok = (i_trig_value & ~prev_q & d_q)
                  | (~i_trig_value & prev_q & ~d_q);
   assign bit_ok  = (i_trig_edge & edge_ok) | (~i_trig_edge & lvl_ok);
   assign trig_hit = &(bit_ok | ~i_trig_mask);

   assign psc_lim = (i_prescaler == 32'd0) ? 32'd0 : i_prescaler - 32'd1;
   assign lim     = (i_step_limit == 32'd0) ? 32'd1 : i_step_limit;
   assign tick    = (psc_q == psc_lim);
   assign ts_d    = ts_q + TS_W'(1);
   assign wrap    = tick && (&ts_q);
   assign change  = (d_q != prev_q);
   assign lim_hit = i_do_limit && (count_q >= lim);
   assign count_d = (&count_q) ? count_q : count_q + 32'd1;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W])
               && (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign rd_ok = i_read && !empty;

   // Record request: trigger record when armed, change or wrap when capturing
   always_comb begin
      wr_req = 1'b0;
      rec_ts = '0;
      case (state_q)
         S_ARMED: begin
            wr_req = (trig_hit || i_man_trig) && !i_stop;
         end
         S_CAPTURE: begin
            wr_req = (change || wrap) && !i_stop && !lim_hit;
            rec_ts = tick ? ts_d : ts_q;
         end
         default: wr_req = 1'b0;
      endcase
   end

   assign wr_ok   = wr_req && (!full || rd_ok);
   assign wr_drop = wr_req && full && !rd_ok;
   assign rec     = {rec_ts, d_q};

   // Capture FSM with counters, timestamp and overflow flag
   always_ff @(posedge i_clk) begin
      if (!_mrst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         ovf_q   <= 1'b0;
         psc_q   <= '0;
         ts_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (i_arm) begin
                  state_q <= S_ARMED;
                  count_q <= '0;
                  ovf_q   <= 1'b0;
                  psc_q   <= '0;
                  ts_q    <= '0;
               end
            end
            S_ARMED: begin
               if (i_stop) begin
                  state_q <= S_IDLE;
               end else if (wr_ok) begin
                  count_q <= count_d;
                  state_q <= S_CAPTURE;
               end else if (wr_drop) begin
                  ovf_q   <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_CAPTURE: begin
               psc_q <= tick ? 32'd0 : psc_q + 32'd1;
               if (tick) ts_q <= ts_d;
               if (wr_ok) count_q <= count_d;
               if (wr_drop) ovf_q <= 1'b1;
               if (i_stop || lim_hit || wr_drop ||
                   (wr_ok && i_do_limit && count_d >= lim))
                  state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // FIFO pointers; flush beats any same-cycle read or write
   always_ff @(posedge i_clk) begin
      if (!_mrst || i_clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(1);
         if (rd_ok) rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(1);
      end
   end

   // Sample storage
   always_ff @(posedge i_clk) begin
      if (wr_ok) mem_q[wr_ptr_q[ADDR_W-1:0]] <= rec;
   end

   assign o_data      = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
   assign o_available = !empty;
   assign o_full      = full;
   assign o_run       = (state_q == S_ARMED) || (state_q == S_CAPTURE);
   assign o_trig      = (state_q == S_CAPTURE);
   assign o_done      = (state_q == S_DONE);
   assign o_overflow  = ovf_q;
   assign o_count     = count_q;

endmodule
